mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (I) and
// memory (D) pipeline stages. D normally wins a collision. A 2-bit starvation
// counter hands the port to I after three D wins in a row while I waits.
// Memory-side outputs are registered and held for the whole transaction.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  // fetch stage
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IRdy,
  output logic [DATA_W-1:0] IRdata,
  // memory stage
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DRdy,
  output logic [DATA_W-1:0] DRdata,
  // shared memory
  output logic              MReq,
  output logic              MWe,
  output logic [ADDR_W-1:0] MAddr,
  output logic [DATA_W-1:0] MWdata,
  input  logic [DATA_W-1:0] MRdata,
  input  logic              MAck,
  // pipeline stalls
  output logic              IStall,
  output logic              DStall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] starve_r;
  logic       i_valid_s;
  logic       d_valid_s;
  logic       grant_i_s;
  logic       grant_d_s;

  // Arbitration and next-state decode; a requester whose Rdy is high this
  // cycle is finishing, so its still-high Req is not a new request.
  always_comb begin
    i_valid_s   = IReq & ~IRdy;
    d_valid_s   = DReq & ~DRdy;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (d_valid_s && !(i_valid_s && (starve_r == 2'd3))) begin
          grant_d_s   = 1'b1;
          state_nxt_s = DBUSY;
        end else if (i_valid_s) begin
          grant_i_s   = 1'b1;
          state_nxt_s = IBUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IBUSY: begin
        if (MAck) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IBUSY;
        end
      end
      DBUSY: begin
        if (MAck) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DBUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and saturating starvation counter (counts D wins while I waits).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r  <= IDLE;
      starve_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_i_s) begin
        starve_r <= 2'd0;
      end else if (grant_d_s && i_valid_s && (starve_r != 2'd3)) begin
        starve_r <= starve_r + 2'd1;
      end else begin
        starve_r <= starve_r;
      end
    end
  end

  // Memory-side request: latched at grant, held constant until MAck.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      MReq   <= 1'b0;
      MWe    <= 1'b0;
      MAddr  <= {ADDR_W{1'b0}};
      MWdata <= {DATA_W{1'b0}};
    end else if (grant_d_s) begin
      MReq   <= 1'b1;
      MWe    <= DWe;
      MAddr  <= DAddr;
      MWdata <= DWdata;
    end else if (grant_i_s) begin
      MReq   <= 1'b1;
      MWe    <= 1'b0;
      MAddr  <= IAddr;
    end else if ((state_r != IDLE) && MAck) begin
      MReq   <= 1'b0;
    end else begin
      MReq   <= MReq;
    end
  end

  // Completion pulses and read-data capture; MAck outside a transaction is ignored.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      IRdy   <= 1'b0;
      DRdy   <= 1'b0;
      IRdata <= {DATA_W{1'b0}};
      DRdata <= {DATA_W{1'b0}};
    end else begin
      IRdy <= (state_r == IBUSY) && MAck;
      DRdy <= (state_r == DBUSY) && MAck;
      if ((state_r == IBUSY) && MAck) begin
        IRdata <= MRdata;
      end else begin
        IRdata <= IRdata;
      end
      if ((state_r == DBUSY) && MAck && !MWe) begin
        DRdata <= MRdata;
      end else begin
        DRdata <= DRdata;
      end
    end
  end

  assign IStall = IReq & ~IRdy;
  assign DStall = DReq & ~DRdy;

endmodule
